// File: rtl/onehot_pulse_dispatcher.sv
// Index FIFO feeding a pulse FSM that drives one output line high for max(hold_cycles,1) cycles.
// Optional ONEHOT_GAP_EN inserts one all-zero cycle between consecutive pulses.
module onehot_pulse_dispatcher #(
  parameter int IDX_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_W     = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [IDX_W-1:0]                in_idx,
  output logic                            in_ready,
  input  logic [HOLD_W-1:0]               hold_cycles,
  output logic [(2**IDX_W)-1:0]           out_oh,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic [1:0]                      dbg_state
);
  localparam int N_OUT = 2**IDX_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Handshake: an index is taken on a rising edge where in_valid && in_ready;
  // in_ready is derived only from registered occupancy, never from in_valid.
`ifdef ONEHOT_GAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1, S_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRIVE = 2'd1} state_t;
`endif

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [N_OUT-1:0]    oh_q, oh_d;
  logic [IDX_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic                full, empty, push, pop, want_load;

  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign push     = in_valid && !full;
  assign in_ready = !full;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    oh_d      = oh_q;
    pop       = 1'b0;
    want_load = 1'b0;
    case (state_q)
      S_IDLE:  want_load = 1'b1;
`ifdef ONEHOT_GAP_EN
      S_GAP:   want_load = 1'b1;
`endif
      S_DRIVE: begin
        if (cnt_q == HOLD_W'(1)) begin
`ifdef ONEHOT_GAP_EN
          state_d = S_GAP;
          oh_d    = '0;
`else
          want_load = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        oh_d    = '0;
      end
    endcase
    // Loading a new pulse is the only way the FIFO is popped.
    if (want_load) begin
      if (!empty) begin
        pop               = 1'b1;
        state_d           = S_DRIVE;
        oh_d              = '0;
        oh_d[mem_q[rd_ptr_q]] = 1'b1;
        cnt_d             = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
      end else begin
        state_d = S_IDLE;
        oh_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      oh_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oh_q    <= oh_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_idx;
  end

  assign out_oh    = oh_q;
  assign level     = level_q;
  assign busy      = (state_q != S_IDLE) || !empty;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_onehot_pulse_dispatcher.sv
// Directed bench for onehot_pulse_dispatcher: cycle model compared every cycle plus literal sequences.
module tb_onehot_pulse_dispatcher;
  localparam int DEPTH = 4;
`ifdef ONEHOT_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_idx = '0;
  logic       in_ready;
  logic [3:0] hold_cycles = '0;
  logic [7:0] out_oh;
  logic       busy;
  logic [2:0] level;
  logic [1:0] dbg_state;

  int vectors = 0;
  int miscompares = 0;

  onehot_pulse_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_idx(in_idx),
    .in_ready(in_ready), .hold_cycles(hold_cycles), .out_oh(out_oh),
    .busy(busy), .level(level), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: queue of pending indices plus the current pulse's remaining length
  int m_q[$];
  int m_rem = 0;
  int m_idx = 0;
  bit m_gap = 1'b0;
  bit m_push;
  int m_pv;
  int m_h;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rem = 0;
      m_gap = 1'b0;
    end else begin
      m_push = in_valid && (m_q.size() < DEPTH);
      m_pv   = int'(in_idx);
      m_h    = (hold_cycles == 0) ? 1 : int'(hold_cycles);
      if (m_rem > 1) begin
        m_rem--;
      end else if (m_rem == 1 && GAP_EN) begin
        m_rem = 0;
        m_gap = 1'b1;
      end else begin
        m_gap = 1'b0;
        if (m_q.size() > 0) begin
          m_idx = m_q.pop_front();
          m_rem = m_h;
        end else begin
          m_rem = 0;
        end
      end
      if (m_push) m_q.push_back(m_pv);
    end
  end

  // scoreboard: every-cycle compare plus optional output recorder
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  bit rec_en = 1'b0;
  logic [7:0] m_oh;

  always @(negedge clk) begin
    m_oh = (m_rem > 0) ? (8'd1 << m_idx) : 8'd0;
    check("out_oh", 32'(out_oh), 32'(m_oh));
    check("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    check("level", 32'(level), 32'(m_q.size()));
    check("busy", 32'(busy), 32'((m_rem > 0) || m_gap || (m_q.size() != 0)));
    if (rec_en) obs_q.push_back(out_oh);
  end

  // driver tasks
  task automatic push_idx(input int idx);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_idx   = 3'(idx);
    for (int n = 0; n < 100; n++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300 && busy; n++) @(negedge clk);
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  int idx_list[$];

  task automatic build_exp(input int hold);
    int h;
    h = (hold == 0) ? 1 : hold;
    exp_q.delete();
    foreach (idx_list[i]) begin
      repeat (h) exp_q.push_back(8'd1 << idx_list[i]);
      if (GAP_EN && i != idx_list.size() - 1) exp_q.push_back(8'h00);
    end
    exp_q.push_back(8'h00);
  endtask

  task automatic start_rec();
    obs_q.delete();
    rec_en = 1'b1;
  endtask

  task automatic compare_rec(input string nm);
    rec_en = 1'b0;
    while (obs_q.size() > 0 && obs_q[0] == 8'h00) void'(obs_q.pop_front());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check(nm, 32'(obs_q[i]), 32'(exp_q[i]));
      else                  check({nm, "_short"}, 32'hDEAD, 32'(exp_q[i]));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_oh", 32'(out_oh), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);

    // single event, hold changed mid-pulse must not matter
    hold_cycles = 4'd3;
    start_rec();
    push_idx(5);
    @(negedge clk);
    check("single_first", 32'(out_oh), 32'h20);
    hold_cycles = 4'd9;
    wait_idle();
    exp_q.delete();
    repeat (3) exp_q.push_back(8'h20);
    exp_q.push_back(8'h00);
    compare_rec("single_seq");
    check("single_busy", 32'(busy), 32'd0);

    // hold = 0 behaves as 1
    hold_cycles = 4'd0;
    start_rec();
    push_idx(0);
    wait_idle();
    exp_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    compare_rec("hold0_seq");

    // burst
    hold_cycles = 4'd2;
    idx_list = {7, 2, 4, 1, 6};
    start_rec();
    foreach (idx_list[i]) push_idx(idx_list[i]);
    wait_idle();
    build_exp(2);
    compare_rec("burst_seq");

    // fill FIFO, stall the producer, order across pointer wrap
    hold_cycles = 4'd4;
    idx_list = {3, 1, 6, 2, 5, 7};
    start_rec();
    for (int i = 0; i < 5; i++) push_idx(idx_list[i]);
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    push_idx(idx_list[5]);
    wait_idle();
    build_exp(4);
    compare_rec("wrap_seq");

    // repeated index
    hold_cycles = 4'd1;
    idx_list = {3, 3};
    start_rec();
    push_idx(3);
    push_idx(3);
    wait_idle();
    build_exp(1);
    compare_rec("repeat_seq");

    // reset mid-pulse discards the queue
    hold_cycles = 4'd8;
    push_idx(4);
    push_idx(6);
    @(negedge clk);
    check("pre_rst_oh", 32'(out_oh), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_oh", 32'(out_oh), 32'h0);
    check("async_rst_level", 32'(level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("post_rst_oh", 32'(out_oh), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
